clk_gen_div_ctrl: RTL and testbench

//   Parametrised, glitch-free programmable clock divider for the clk_gen family.

---
 rtl/clk_gen_div_ctrl.sv | 146 ++++++++++++++
 tb/tb_clk_gen_div_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_gen_div_ctrl.sv
// Glitch-free programmable clock divider: clk_o = clk_i / (2*(div_o+1)), 50% duty,
// with a divide value reloaded by valid/ready handshake and applied only at a period boundary.
module clk_gen_div_ctrl #(
  parameter int WIDTH_P       = 8,
  parameter int DEFAULT_DIV_P = 1,
  parameter int CNT_WIDTH_P   = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   en_i,
  input  logic                   div_v_i,
  input  logic [WIDTH_P-1:0]     div_i,
  output logic                   div_ready_o,
  output logic [WIDTH_P-1:0]     div_o,
  output logic                   clk_o,
  output logic                   tick_o,
  output logic                   running_o,
  output logic [CNT_WIDTH_P-1:0] period_cnt_o
);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUN     = 1'b1
  } state_e;

  localparam logic [WIDTH_P-1:0] DEFAULT_DIV_L = WIDTH_P'(DEFAULT_DIV_P);

  state_e                 state_q, state_d;
  logic [WIDTH_P-1:0]     cnt_q, cnt_d;
  logic                   clk_q, clk_d;
  logic                   tick_q, tick_d;
  logic [WIDTH_P-1:0]     div_q, div_d;
  logic                   pend_q, pend_d;
  logic [WIDTH_P-1:0]     n_pend_q, n_pend_d;
  logic [CNT_WIDTH_P-1:0] period_cnt_q, period_cnt_d;

  logic at_boundary;
  logic accept;

  // Boundary: last cycle of the low phase; the only point where ratio or run state may change.
  assign at_boundary = (state_q == ST_RUN) && !clk_q && (cnt_q == div_q);
  assign accept      = div_v_i && !pend_q;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= ST_STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOPPED: if (en_i) state_d = ST_RUN;
      ST_RUN:     if (at_boundary && !en_i) state_d = ST_STOPPED;
      default:    state_d = ST_STOPPED;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q        <= '0;
      clk_q        <= 1'b0;
      tick_q       <= 1'b0;
      div_q        <= DEFAULT_DIV_L;
      pend_q       <= 1'b0;
      n_pend_q     <= '0;
      period_cnt_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      clk_q        <= clk_d;
      tick_q       <= tick_d;
      div_q        <= div_d;
      pend_q       <= pend_d;
      n_pend_q     <= n_pend_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  // Datapath next-value logic
  always_comb begin
    // NOTE: every combinational target gets a default first so no path infers a latch.
    cnt_d        = cnt_q;
    clk_d        = clk_q;
    tick_d       = 1'b0;
    div_d        = div_q;
    pend_d       = pend_q;
    n_pend_d     = n_pend_q;
    period_cnt_d = period_cnt_q;

    case (state_q)
      ST_STOPPED: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (pend_q) begin
          div_d  = n_pend_q;
          pend_d = 1'b0;
        end
        if (en_i) begin
          clk_d  = 1'b1;
          tick_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (at_boundary) begin
          period_cnt_d = period_cnt_q + CNT_WIDTH_P'(1);
          cnt_d        = '0;
          if (pend_q) begin
            div_d  = n_pend_q;
            pend_d = 1'b0;
          end
          clk_d  = en_i;
          tick_d = en_i;
        end else if (cnt_q == div_q) begin
          cnt_d = '0;
          clk_d = ~clk_q;
        end else begin
          cnt_d = cnt_q + WIDTH_P'(1);
        end
      end
      default: ;
    endcase

    // Accept only when nothing is pending, so this never collides with the apply above.
    if (accept) begin
      n_pend_d = div_i;
      pend_d   = 1'b1;
    end
  end

  // Output logic
  always_comb begin
    running_o    = (state_q == ST_RUN);
    clk_o        = clk_q;
    tick_o       = tick_q;
    div_o        = div_q;
    div_ready_o  = ~pend_q;
    period_cnt_o = period_cnt_q;
  end

endmodule

// File: tb/tb_clk_gen_div_ctrl.sv
// Self-checking bench for clk_gen_div_ctrl: directed scenarios plus random stimulus,
// checked every cycle against a period-position reference model.
module tb_clk_gen_div_ctrl;

  localparam int W   = 8;
  localparam int CW  = 4;
  localparam int DEF = 1;

  logic          clk_i;
  logic          reset_n_i;
  logic          en_i;
  logic          div_v_i;
  logic [W-1:0]  div_i;
  logic          div_ready_o;
  logic [W-1:0]  div_o;
  logic          clk_o;
  logic          tick_o;
  logic          running_o;
  logic [CW-1:0] period_cnt_o;

  clk_gen_div_ctrl #(
    .WIDTH_P      (W),
    .DEFAULT_DIV_P(DEF),
    .CNT_WIDTH_P  (CW)
  ) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .en_i        (en_i),
    .div_v_i     (div_v_i),
    .div_i       (div_i),
    .div_ready_o (div_ready_o),
    .div_o       (div_o),
    .clk_o       (clk_o),
    .tick_o      (tick_o),
    .running_o   (running_o),
    .period_cnt_o(period_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position inside the current period (0 .. 2*(N+1)-1).
  // High phase is positions 0..N, tick on position 0, period ends on the last position.
  bit m_run;
  int m_pos;
  int m_n;
  bit m_pend;
  int m_npend;
  int m_per;

  task automatic model_reset();
    m_run   = 0;
    m_pos   = 0;
    m_n     = DEF;
    m_pend  = 0;
    m_npend = 0;
    m_per   = 0;
  endtask

  task automatic model_step(input bit en, input bit v, input int d);
    bit acc;
    acc = v && !m_pend;
    if (!m_run) begin
      if (m_pend) begin
        m_n    = m_npend;
        m_pend = 0;
      end
      if (en) begin
        m_run = 1;
        m_pos = 0;
      end
    end else if (m_pos == 2 * (m_n + 1) - 1) begin
      m_per = (m_per + 1) % (1 << CW);
      if (m_pend) begin
        m_n    = m_npend;
        m_pend = 0;
      end
      if (en) m_pos = 0;
      else    m_run = 0;
    end else begin
      m_pos++;
    end
    if (acc) begin
      m_npend = d;
      m_pend  = 1;
    end
  endtask

  task automatic check_all();
    check("clk_o",        32'(clk_o),        32'(m_run && (m_pos < m_n + 1)));
    check("tick_o",       32'(tick_o),       32'(m_run && (m_pos == 0)));
    check("running_o",    32'(running_o),    32'(m_run));
    check("div_ready_o",  32'(div_ready_o),  32'(!m_pend));
    check("div_o",        32'(div_o),        32'(m_n));
    check("period_cnt_o", 32'(period_cnt_o), 32'(m_per));
  endtask

  // One clock: drive at the falling edge, model the rising edge, compare at the next falling edge.
  task automatic cycle(input bit en, input bit v, input int d);
    logic [W-1:0] dv;
    dv      = W'(d);
    en_i    = en;
    div_v_i = v;
    div_i   = dv;
    @(posedge clk_i);
    model_step(en, v, int'(dv));
    @(negedge clk_i);
    check_all();
  endtask

  // Run with en_i=1 until the DUT sits in the first high cycle of a period.
  task automatic run_to_tick(input string tag);
    int budget;
    budget = 64;
    while (!(m_run && m_pos == 0) && budget > 0) begin
      cycle(1, 0, 0);
      budget--;
    end
    if (budget == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic async_reset_mid_cycle();
    #2 reset_n_i = 1'b0;
    #1;
    check("rst_clk_o",    32'(clk_o),        32'd0);
    check("rst_div_o",    32'(div_o),        32'(DEF));
    check("rst_ready",    32'(div_ready_o),  32'd1);
    check("rst_period",   32'(period_cnt_o), 32'd0);
    check("rst_running",  32'(running_o),    32'd0);
    model_reset();
    @(posedge clk_i);
    @(negedge clk_i);
    check_all();
    reset_n_i = 1'b1;
  endtask

  initial begin
    int  budget;
    bit  saw_wrap;
    logic [CW-1:0] prev_per;

    reset_n_i = 1'b0;
    en_i      = 1'b0;
    div_v_i   = 1'b0;
    div_i     = '0;
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    check_all();
    reset_n_i = 1'b1;

    // Default ratio 4: 1,1,0,0 with a tick every 4 cycles.
    for (int i = 0; i < 12; i++) cycle(1, 0, 0);

    // New value accepted mid high phase, then a second offer while pending is dropped.
    run_to_tick("t2");
    cycle(1, 1, 3);
    check("t2_ready_low", 32'(div_ready_o), 32'd0);
    cycle(1, 1, 7);
    for (int i = 0; i < 14; i++) cycle(1, 0, 0);
    check("t3_div_is_3", 32'(div_o), 32'd3);

    // N=2, drop en_i in the second high cycle: period completes, then stop.
    cycle(1, 1, 2);
    budget = 64;
    while (!(m_n == 2 && m_run && m_pos == 1) && budget > 0) begin
      cycle(1, 0, 0);
      budget--;
    end
    if (budget == 0) check("t4_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0);
    check("t4_stopped", 32'(running_o), 32'd0);
    cycle(1, 0, 0);
    check("t4_restart_tick", 32'(tick_o), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0);

    // Asynchronous reset during a high phase, with a value pending.
    run_to_tick("t5");
    cycle(1, 1, 5);
    async_reset_mid_cycle();

    // N=0: ratio 2, 4-bit period counter wraps.
    cycle(0, 1, 0);
    cycle(0, 0, 0);
    saw_wrap = 0;
    prev_per = period_cnt_o;
    for (int i = 0; i < 40; i++) begin
      cycle(1, 0, 0);
      if (prev_per == CW'(15) && period_cnt_o == '0) saw_wrap = 1;
      prev_per = period_cnt_o;
    end
    check("t6_wrap_seen", 32'(saw_wrap), 32'd1);

    // Random traffic with occasional asynchronous resets.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset_mid_cycle();
      end else begin
        cycle($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
              int'($urandom_range(0, 5)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
